// File: rtl/pkt_sfifo.sv
// Single-clock packet FIFO: commit/discard of whole frames, overflow auto-drop,
// registered almost-full/almost-empty flags and an optional first-word-fall-through read port.
module pkt_sfifo #(
    parameter int DATA_WIDTH         = 16,
    parameter int ADDR_WIDTH         = 8,
    parameter int ALMOST_FULL_DEPTH  = 240,
    parameter int ALMOST_EMPTY_DEPTH = 4,
    parameter int FWFT               = 0
) (
    input  logic                  clk,
    input  logic                  ainit_n,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  wr_en,
    input  logic                  wr_eop,
    input  logic                  wr_drop,
    output logic                  full,
    output logic                  almost_full,
    output logic                  wr_ack,
    output logic                  wr_ovf,
    output logic [ADDR_WIDTH:0]   wr_count,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  empty,
    output logic                  almost_empty,
    output logic                  rd_ack,
    output logic [ADDR_WIDTH:0]   rd_count
);

    localparam logic [ADDR_WIDTH:0] DEPTH_W = {1'b1, {ADDR_WIDTH{1'b0}}};

    logic [DATA_WIDTH-1:0] mem [0:(1<<ADDR_WIDTH)-1];

    logic [ADDR_WIDTH:0] wr_ptr;
    logic [ADDR_WIDTH:0] cm_ptr;
    logic [ADDR_WIDTH:0] rd_ptr;
    logic                ovf_flag;

    logic wr_accept;
    logic ovf_start;
    logic ovf_end;

    assign wr_count = wr_ptr - rd_ptr;
    assign rd_count = cm_ptr - rd_ptr;
    assign full     = (wr_count == DEPTH_W);

    assign wr_accept = wr_en && !full && !wr_drop && !ovf_flag;
    assign ovf_start = wr_en && full && !wr_drop && !ovf_flag;
    assign ovf_end   = wr_en && wr_eop && ovf_flag && !wr_drop;

    // Overflow rewinds to the last commit point, throwing away the partial frame.
    always_ff @(posedge clk or negedge ainit_n) begin
        if (!ainit_n) begin
            wr_ptr   <= '0;
            cm_ptr   <= '0;
            ovf_flag <= 1'b0;
            wr_ack   <= 1'b0;
            wr_ovf   <= 1'b0;
        end else begin
            wr_ack <= wr_accept;
            wr_ovf <= ovf_end;
            if (wr_drop || ovf_end) begin
                wr_ptr   <= cm_ptr;
                ovf_flag <= 1'b0;
            end else if (ovf_start) begin
                ovf_flag <= 1'b1;
            end else if (wr_accept) begin
                wr_ptr <= wr_ptr + 1'b1;
                if (wr_eop) begin
                    cm_ptr <= wr_ptr + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem[wr_ptr[ADDR_WIDTH-1:0]] <= din;
        end
    end

    always_ff @(posedge clk or negedge ainit_n) begin
        if (!ainit_n) begin
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
        end else begin
            almost_full  <= (int'(wr_count) >= ALMOST_FULL_DEPTH);
            almost_empty <= (int'(rd_count) <= ALMOST_EMPTY_DEPTH);
        end
    end

    generate
        if (FWFT == 0) begin : g_std
            logic rd_fire;

            assign empty   = (rd_count == '0);
            assign rd_fire = rd_en && !empty;

            always_ff @(posedge clk or negedge ainit_n) begin
                if (!ainit_n) begin
                    rd_ptr <= '0;
                    rd_ack <= 1'b0;
                    dout   <= '0;
                end else begin
                    rd_ack <= rd_fire;
                    if (rd_fire) begin
                        rd_ptr <= rd_ptr + 1'b1;
                        dout   <= mem[rd_ptr[ADDR_WIDTH-1:0]];
                    end
                end
            end
        end else begin : g_fwft
            // rd_ptr counts popped words; fe_ptr runs ahead feeding the RAM stage and dout.
            logic [ADDR_WIDTH:0]   fe_ptr;
            logic [DATA_WIDTH-1:0] ram_q;
            logic                  ram_v;
            logic                  out_v;
            logic                  pop;
            logic                  load;
            logic                  fetch;

            assign empty  = !out_v;
            assign rd_ack = 1'b0;
            assign pop    = rd_en && out_v;
            assign load   = ram_v && (!out_v || pop);
            assign fetch  = (fe_ptr != cm_ptr) && (!ram_v || load);

            always_ff @(posedge clk or negedge ainit_n) begin
                if (!ainit_n) begin
                    rd_ptr <= '0;
                    fe_ptr <= '0;
                    ram_q  <= '0;
                    ram_v  <= 1'b0;
                    out_v  <= 1'b0;
                    dout   <= '0;
                end else begin
                    if (pop) begin
                        rd_ptr <= rd_ptr + 1'b1;
                    end
                    if (fetch) begin
                        ram_q  <= mem[fe_ptr[ADDR_WIDTH-1:0]];
                        fe_ptr <= fe_ptr + 1'b1;
                        ram_v  <= 1'b1;
                    end else if (load) begin
                        ram_v <= 1'b0;
                    end
                    if (load) begin
                        dout  <= ram_q;
                        out_v <= 1'b1;
                    end else if (pop) begin
                        out_v <= 1'b0;
                    end
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_pkt_sfifo.sv
// Bench for pkt_sfifo: a standard-read and an FWFT instance share one stimulus stream,
// each checked against a frame-level queue model with a decoupled read-data scoreboard.
module tb_pkt_sfifo;

    localparam int DW    = 16;
    localparam int AW    = 4;
    localparam int DEPTH = 16;
    localparam int AFD   = 12;
    localparam int AED   = 2;

    logic          clk = 1'b0;
    logic          ainit_n = 1'b0;
    logic [DW-1:0] din = '0;
    logic          wr_en = 1'b0;
    logic          wr_eop = 1'b0;
    logic          wr_drop = 1'b0;
    logic          rd_en = 1'b0;

    logic          full_a, almost_full_a, wr_ack_a, wr_ovf_a, empty_a, almost_empty_a, rd_ack_a;
    logic [AW:0]   wr_count_a, rd_count_a;
    logic [DW-1:0] dout_a;
    logic          full_b, almost_full_b, wr_ack_b, wr_ovf_b, empty_b, almost_empty_b, rd_ack_b;
    logic [AW:0]   wr_count_b, rd_count_b;
    logic [DW-1:0] dout_b;

    always #5 clk = ~clk;

    pkt_sfifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ALMOST_FULL_DEPTH(AFD),
                .ALMOST_EMPTY_DEPTH(AED), .FWFT(0)) dut_a (
        .clk(clk), .ainit_n(ainit_n), .din(din), .wr_en(wr_en), .wr_eop(wr_eop),
        .wr_drop(wr_drop), .full(full_a), .almost_full(almost_full_a), .wr_ack(wr_ack_a),
        .wr_ovf(wr_ovf_a), .wr_count(wr_count_a), .rd_en(rd_en), .dout(dout_a),
        .empty(empty_a), .almost_empty(almost_empty_a), .rd_ack(rd_ack_a), .rd_count(rd_count_a)
    );

    pkt_sfifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ALMOST_FULL_DEPTH(AFD),
                .ALMOST_EMPTY_DEPTH(AED), .FWFT(1)) dut_b (
        .clk(clk), .ainit_n(ainit_n), .din(din), .wr_en(wr_en), .wr_eop(wr_eop),
        .wr_drop(wr_drop), .full(full_b), .almost_full(almost_full_b), .wr_ack(wr_ack_b),
        .wr_ovf(wr_ovf_b), .wr_count(wr_count_b), .rd_en(rd_en), .dout(dout_b),
        .empty(empty_b), .almost_empty(almost_empty_b), .rd_ack(rd_ack_b), .rd_count(rd_count_b)
    );

    int n_checks = 0;
    int n_fails  = 0;

    logic [DW-1:0] exp_a[$];
    logic [DW-1:0] exp_b[$];
    logic [DW-1:0] pend_a[$];
    logic [DW-1:0] pend_b[$];
    int comm_a = 0;
    int comm_b = 0;
    bit ovf_a = 0, ovf_b = 0;
    bit ack_a_exp = 0, wovf_a_exp = 0, rdack_a_exp = 0, af_a_exp = 0, ae_a_exp = 1;
    bit ack_b_exp = 0, wovf_b_exp = 0, af_b_exp = 0, ae_b_exp = 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fails++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    // Frame-level model of the standard instance: pending words, committed-unread count.
    task automatic stepA(input logic en, input logic eop, input logic drop, input logic rden,
                         input logic [DW-1:0] d);
        int held = pend_a.size() + comm_a;
        bit fire = rden && (comm_a > 0);
        af_a_exp    = (held >= AFD);
        ae_a_exp    = (comm_a <= AED);
        ack_a_exp   = 0;
        wovf_a_exp  = 0;
        rdack_a_exp = fire;
        if (drop) begin
            pend_a.delete();
            ovf_a = 0;
        end else if (ovf_a) begin
            if (en && eop) begin
                pend_a.delete();
                ovf_a = 0;
                wovf_a_exp = 1;
            end
        end else if (en && held == DEPTH) begin
            ovf_a = 1;
        end else if (en) begin
            pend_a.push_back(d);
            ack_a_exp = 1;
            if (eop) begin
                foreach (pend_a[i]) exp_a.push_back(pend_a[i]);
                comm_a += pend_a.size();
                pend_a.delete();
            end
        end
        if (fire) comm_a--;
    endtask

    // Same frame rules for the FWFT instance; a pop happens whenever it shows a word and rd_en is high.
    task automatic stepB(input logic en, input logic eop, input logic drop, input logic pop,
                         input logic [DW-1:0] d);
        int held = pend_b.size() + comm_b;
        af_b_exp   = (held >= AFD);
        ae_b_exp   = (comm_b <= AED);
        ack_b_exp  = 0;
        wovf_b_exp = 0;
        if (drop) begin
            pend_b.delete();
            ovf_b = 0;
        end else if (ovf_b) begin
            if (en && eop) begin
                pend_b.delete();
                ovf_b = 0;
                wovf_b_exp = 1;
            end
        end else if (en && held == DEPTH) begin
            ovf_b = 1;
        end else if (en) begin
            pend_b.push_back(d);
            ack_b_exp = 1;
            if (eop) begin
                foreach (pend_b[i]) exp_b.push_back(pend_b[i]);
                comm_b += pend_b.size();
                pend_b.delete();
            end
        end
        if (pop && comm_b > 0) comm_b--;
    endtask

    task automatic checkOutput();
        check("a_wr_ack", wr_ack_a, ack_a_exp);
        check("a_wr_ovf", wr_ovf_a, wovf_a_exp);
        check("a_wr_count", wr_count_a, pend_a.size() + comm_a);
        check("a_rd_count", rd_count_a, comm_a);
        check("a_full", full_a, (pend_a.size() + comm_a) == DEPTH);
        check("a_empty", empty_a, comm_a == 0);
        check("a_almost_full", almost_full_a, af_a_exp);
        check("a_almost_empty", almost_empty_a, ae_a_exp);
        check("a_rd_ack", rd_ack_a, rdack_a_exp);
        check("b_wr_ack", wr_ack_b, ack_b_exp);
        check("b_wr_ovf", wr_ovf_b, wovf_b_exp);
        check("b_wr_count", wr_count_b, pend_b.size() + comm_b);
        check("b_rd_count", rd_count_b, comm_b);
        check("b_full", full_b, (pend_b.size() + comm_b) == DEPTH);
        check("b_almost_full", almost_full_b, af_b_exp);
        check("b_almost_empty", almost_empty_b, ae_b_exp);
        check("b_rd_ack", rd_ack_b, 0);
        if (comm_b == 0) check("b_empty_when_none", empty_b, 1);
    endtask

    task automatic applyStimulus(input logic en, input logic eop, input logic drop,
                                 input logic rden, input logic [DW-1:0] d);
        din     = d;
        wr_en   = en;
        wr_eop  = eop;
        wr_drop = drop;
        rd_en   = rden;
        stepA(en, eop, drop, rden, d);
        stepB(en, eop, drop, rden && !empty_b, d);
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    task automatic idle(input logic rden, input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, rden, '0);
    endtask

    task automatic checkReset();
        check("rst_a_empty", empty_a, 1);
        check("rst_a_almost_empty", almost_empty_a, 1);
        check("rst_a_full", full_a, 0);
        check("rst_a_almost_full", almost_full_a, 0);
        check("rst_a_wr_ack", wr_ack_a, 0);
        check("rst_a_rd_ack", rd_ack_a, 0);
        check("rst_a_wr_ovf", wr_ovf_a, 0);
        check("rst_a_dout", dout_a, 0);
        check("rst_a_wr_count", wr_count_a, 0);
        check("rst_a_rd_count", rd_count_a, 0);
        check("rst_b_empty", empty_b, 1);
        check("rst_b_almost_empty", almost_empty_b, 1);
        check("rst_b_full", full_b, 0);
        check("rst_b_almost_full", almost_full_b, 0);
        check("rst_b_wr_ack", wr_ack_b, 0);
        check("rst_b_wr_ovf", wr_ovf_b, 0);
        check("rst_b_dout", dout_b, 0);
        check("rst_b_wr_count", wr_count_b, 0);
        check("rst_b_rd_count", rd_count_b, 0);
    endtask

    task automatic clearModel();
        exp_a.delete(); exp_b.delete(); pend_a.delete(); pend_b.delete();
        comm_a = 0; comm_b = 0; ovf_a = 0; ovf_b = 0;
        ack_a_exp = 0; wovf_a_exp = 0; rdack_a_exp = 0; af_a_exp = 0; ae_a_exp = 1;
        ack_b_exp = 0; wovf_b_exp = 0; af_b_exp = 0; ae_b_exp = 1;
    endtask

    // Read-data scoreboard: popped whenever a DUT presents a word.
    always @(negedge clk) begin
        if (ainit_n && rd_ack_a) begin
            if (exp_a.size() == 0) begin
                n_checks++; n_fails++;
                $display("[TB] FAIL a_dout: got %0h expected no word", dout_a);
            end else begin
                check("a_dout", dout_a, exp_a.pop_front());
            end
        end
        if (ainit_n && rd_en && !empty_b) begin
            if (exp_b.size() == 0) begin
                n_checks++; n_fails++;
                $display("[TB] FAIL b_dout: got %0h expected no word", dout_b);
            end else begin
                check("b_dout", dout_b, exp_b.pop_front());
            end
        end
    end

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        #23;
        checkReset();
        @(posedge clk); #1;
        ainit_n = 1'b1;
        idle(1'b0, 2);

        $display("[TB] three-word frame");
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 16'h00A1);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 16'h00A2);
        check("frame_empty_before_commit", empty_a, 1);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 16'h00A3);
        check("frame_rd_count", rd_count_a, 3);
        check("frame_visible", empty_a, 0);
        idle(1'b1, 8);
        check("frame_drained", empty_a, 1);

        $display("[TB] uncommitted drop");
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, DW'(16'h0B00 + i));
        check("drop_wr_count_before", wr_count_a, 5);
        check("drop_empty_before", empty_a, 1);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 16'h0BFF);
        check("drop_wr_count_after", wr_count_a, 0);
        check("drop_rd_count_after", rd_count_a, 0);
        idle(1'b0, 2);

        $display("[TB] fill and overflow");
        for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, i == DEPTH - 1, 1'b0, 1'b0, DW'(16'h0C00 + i));
        check("fill_full", full_a, 1);
        check("fill_wr_count", wr_count_a, DEPTH);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 16'h0CEE);
        check("ovf_no_ack", wr_ack_a, 0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 16'h0CEF);
        check("ovf_pulse_full_commit", wr_ovf_a, 1);
        check("ovf_count_kept", wr_count_a, DEPTH);
        idle(1'b1, 24);
        for (int i = 0; i < 10; i++) applyStimulus(1'b1, i == 9, 1'b0, 1'b0, DW'(16'h0D00 + i));
        for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, DW'(16'h0D80 + i));
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 16'h0DFF);
        check("ovf_pulse_mid_packet", wr_ovf_a, 1);
        check("ovf_rewind_count", wr_count_a, 10);
        idle(1'b1, 24);

        $display("[TB] FWFT latency");
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 16'h1234);
        check("fwft_empty_commit_edge", empty_b, 1);
        idle(1'b0, 1);
        check("fwft_empty_plus1", empty_b, 1);
        idle(1'b0, 1);
        check("fwft_valid_plus2", empty_b, 0);
        check("fwft_dout", dout_b, 16'h1234);
        idle(1'b1, 1);
        check("fwft_empty_after_pop", empty_b, 1);
        idle(1'b1, 2);

        $display("[TB] random packets");
        for (int p = 0; p < 1000; p++) begin
            int len = $urandom_range(1, 20);
            int drop_at = ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, len - 1)) : -1;
            for (int w = 0; w < len; w++) begin
                while ($urandom_range(0, 3) == 0) idle($urandom_range(0, 99) < 55, 1);
                applyStimulus(1'b1, w == len - 1, w == drop_at, $urandom_range(0, 99) < 55,
                              DW'($urandom));
            end
        end
        idle(1'b1, 40);
        check("random_a_scoreboard_empty", exp_a.size(), 0);
        check("random_b_scoreboard_empty", exp_b.size(), 0);

        $display("[TB] reset mid-packet");
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, i == 3, 1'b0, 1'b0, DW'(16'h0E00 + i));
        for (int i = 0; i < 2; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, DW'(16'h0E80 + i));
        idle(1'b0, 2);
        check("pre_reset_rd_count", rd_count_a, 4);
        wr_en = 1'b0;
        #2;
        ainit_n = 1'b0;
        #1;
        checkReset();
        clearModel();
        @(posedge clk); #1;
        ainit_n = 1'b1;
        idle(1'b1, 4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
